// File: rtl/vga_pkg.sv
// VGA 640x480 @ 60 Hz raster timing constants and the timing bundle
// that the raster generator hands to the scan-out stage.
package vga_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = 800;

   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = 525;

   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int CNT_W = 10;

   typedef struct packed {
      logic [CNT_W-1:0] hcnt;
      logic [CNT_W-1:0] vcnt;
      logic             pix_tick;    // last Clk of the current counter state
      logic             state_first; // first Clk of the current counter state
      logic             line_end;    // HCnt wraps on this Clk
      logic             frame_end;   // VCnt wraps on this Clk
      logic             hsync_n;
      logic             vsync_n;
      logic             visible;
   } timing_t;

endpackage

// File: rtl/vga_scan_out_if.sv
// Upstream link between the VGA handler stage and the scan-out back-end.
// ReqIn: upstream offers a new matrix. AckOut high: upstream must hold VgaMat
// stable and not capture; upstream may only load while AckOut is low.
interface vga_scan_out_if #(
   parameter int FLAT_WIDE = 8 * 120 * 120
);
   logic [FLAT_WIDE-1:0] VgaMat;
   logic                 ReqIn;
   logic                 AckOut;

   modport master (output VgaMat, output ReqIn, input AckOut);
   modport slave  (input VgaMat, input ReqIn, output AckOut);
endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider and the 800x525 horizontal/vertical raster counters,
// with combinational sync and visible-area decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic    Clk,
   input  logic    Reset,
   output timing_t tim
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   logic             pix_tick;
   logic             line_end;

   assign pix_tick = (div_q == DIV_W'(CLK_DIV - 1));
   assign line_end = pix_tick && (hcnt_q == CNT_W'(H_TOT - 1));

   always_comb begin
      div_d  = pix_tick ? '0 : div_q + 1'b1;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (line_end) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == CNT_W'(V_TOT - 1)) ? '0 : vcnt_q + 1'b1;
      end else if (pix_tick) begin
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   // Start in vertical blanking so upstream gets a load window before line 0.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         div_q  <= '0;
         hcnt_q <= '0;
         vcnt_q <= CNT_W'(V_VIS);
      end else begin
         div_q  <= div_d;
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   always_comb begin
      tim.hcnt        = hcnt_q;
      tim.vcnt        = vcnt_q;
      tim.pix_tick    = pix_tick;
      tim.state_first = (div_q == '0);
      tim.line_end    = line_end;
      tim.frame_end   = line_end && (vcnt_q == CNT_W'(V_TOT - 1));
      tim.hsync_n     = !((hcnt_q >= CNT_W'(H_SYNC_START)) && (hcnt_q < CNT_W'(H_SYNC_END)));
      tim.vsync_n     = !((vcnt_q >= CNT_W'(V_SYNC_START)) && (vcnt_q < CNT_W'(V_SYNC_END)));
      tim.visible     = (hcnt_q < CNT_W'(H_VIS)) && (vcnt_q < CNT_W'(V_VIS));
   end

endmodule

// File: rtl/vga_scan_out.sv
// Scans the held image matrix out as an upscaled, horizontally centred VGA
// raster and holds off upstream capture during active video.
module vga_scan_out
   import vga_pkg::*;
#(
   parameter int IMAGE_BITS = 8,
   parameter int MATRIX_N   = 120,
   parameter int MATRIX_M   = 120,
   parameter int SCALE      = 4,
   parameter int CLK_DIV    = 2,
   parameter int FLAT_WIDE  = IMAGE_BITS * MATRIX_N * MATRIX_M
) (
   input  logic                  Clk,
   input  logic                  Reset,
   vga_scan_out_if.slave         up,
   output logic                  Hsync,
   output logic                  Vsync,
   output logic                  Blank,
   output logic [IMAGE_BITS-1:0] Pixel,
   output logic                  FrameStart
);

   localparam int H_OFF = (H_VIS - MATRIX_N * SCALE) / 2;
   localparam int H_END = H_OFF + MATRIX_N * SCALE;
   localparam int V_END = MATRIX_M * SCALE;
   localparam int H_CLR = (H_OFF == 0) ? H_TOT - 1 : H_OFF - 1;
   localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int IDX_W = $clog2(FLAT_WIDE + 1);

   timing_t tim;

   vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
      .Clk   (Clk),
      .Reset (Reset),
      .tim   (tim)
   );

   logic [CNT_W-1:0]      col_q, col_d, row_q, row_d;
   logic [SUB_W-1:0]      col_sub_q, col_sub_d, row_sub_q, row_sub_d;
   logic                  hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic                  ack_q, ack_d, fs_q, fs_d, primed_q, primed_d;
   logic [IMAGE_BITS-1:0] pixel_q, pixel_d;
   logic                  in_win;
   logic [IDX_W-1:0]      pix_base;

   // Col/Row run on past the image edge; in_win masks those values.
   always_comb begin
      col_d     = col_q;
      col_sub_d = col_sub_q;
      row_d     = row_q;
      row_sub_d = row_sub_q;
      if (tim.pix_tick) begin
         if (tim.hcnt == CNT_W'(H_CLR)) begin
            col_d     = '0;
            col_sub_d = '0;
         end else if (col_sub_q == SUB_W'(SCALE - 1)) begin
            col_sub_d = '0;
            col_d     = col_q + 1'b1;
         end else begin
            col_sub_d = col_sub_q + 1'b1;
         end
      end
      if (tim.frame_end) begin
         row_d     = '0;
         row_sub_d = '0;
      end else if (tim.line_end) begin
         if (row_sub_q == SUB_W'(SCALE - 1)) begin
            row_sub_d = '0;
            row_d     = row_q + 1'b1;
         end else begin
            row_sub_d = row_sub_q + 1'b1;
         end
      end
   end

   always_comb begin
      in_win   = (tim.hcnt >= CNT_W'(H_OFF)) && (tim.hcnt < CNT_W'(H_END)) &&
                 (tim.vcnt < CNT_W'(V_END));
      pix_base = in_win ? IDX_W'((32'(row_q) * MATRIX_N + 32'(col_q)) * IMAGE_BITS) : '0;
      hsync_d  = tim.hsync_n;
      vsync_d  = tim.vsync_n;
      blank_d  = !tim.visible;
      ack_d    = (tim.vcnt < CNT_W'(V_VIS));
      fs_d     = (tim.hcnt == '0) && (tim.vcnt == '0) && tim.state_first;
      // Registered AckOut is sampled, so a request in the Clk where AckOut rises still primes.
      primed_d = primed_q | (up.ReqIn & ~ack_q);
      pixel_d  = (in_win && primed_q) ? up.VgaMat[pix_base +: IMAGE_BITS] : '0;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         col_q     <= '0;
         col_sub_q <= '0;
         row_q     <= '0;
         row_sub_q <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         blank_q   <= 1'b1;
         ack_q     <= 1'b0;
         fs_q      <= 1'b0;
         primed_q  <= 1'b0;
         pixel_q   <= '0;
      end else begin
         col_q     <= col_d;
         col_sub_q <= col_sub_d;
         row_q     <= row_d;
         row_sub_q <= row_sub_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         blank_q   <= blank_d;
         ack_q     <= ack_d;
         fs_q      <= fs_d;
         primed_q  <= primed_d;
         pixel_q   <= pixel_d;
      end
   end

   assign up.AckOut  = ack_q;
   assign Hsync      = hsync_q;
   assign Vsync      = vsync_q;
   assign Blank      = blank_q;
   assign Pixel      = pixel_q;
   assign FrameStart = fs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a CLK_DIV=1 instance for raster, window, priming and
// reset behaviour, and a CLK_DIV=2 instance for divided sync timing.
module tb_vga_scan_out;
   localparam int IB = 8;
   localparam int MN = 120;
   localparam int MM = 120;
   localparam int FW = IB * MN * MM;

   localparam int S_AHS = 0, S_AVS = 1, S_ABL = 2, S_AACK = 3, S_APIX = 4,
                  S_AFS = 5, S_BHS = 6, S_BVS = 7, S_DRV = 8;

   typedef struct {
      string    nm;
      int       e;    // clock edge after reset release
      int       sig;
      logic [7:0] exp;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset = 1'b0;

   logic          a_hs, a_vs, a_bl, a_fs;
   logic [IB-1:0] a_pix;
   logic          b_hs, b_vs, b_bl, b_fs;
   logic [IB-1:0] b_pix;

   int checks = 0;
   int errors = 0;
   int edges  = 0;

   vga_scan_out_if #(.FLAT_WIDE(FW)) a_if ();
   vga_scan_out_if #(.FLAT_WIDE(FW)) b_if ();

   vga_scan_out #(.IMAGE_BITS(IB), .MATRIX_N(MN), .MATRIX_M(MM), .SCALE(4), .CLK_DIV(1)) dut_a (
      .Clk(Clk), .Reset(Reset), .up(a_if.slave),
      .Hsync(a_hs), .Vsync(a_vs), .Blank(a_bl), .Pixel(a_pix), .FrameStart(a_fs)
   );

   vga_scan_out #(.IMAGE_BITS(IB), .MATRIX_N(MN), .MATRIX_M(MM), .SCALE(4), .CLK_DIV(2)) dut_b (
      .Clk(Clk), .Reset(Reset), .up(b_if.slave),
      .Hsync(b_hs), .Vsync(b_vs), .Blank(b_bl), .Pixel(b_pix), .FrameStart(b_fs)
   );

   // clock
   always #5 Clk = ~Clk;

   function automatic logic [7:0] get_sig(int sig);
      case (sig)
         S_AHS:   return {7'd0, a_hs};
         S_AVS:   return {7'd0, a_vs};
         S_ABL:   return {7'd0, a_bl};
         S_AACK:  return {7'd0, a_if.AckOut};
         S_APIX:  return a_pix;
         S_AFS:   return {7'd0, a_fs};
         S_BHS:   return {7'd0, b_hs};
         S_BVS:   return {7'd0, b_vs};
         default: return 8'hxx;
      endcase
   endfunction

   task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edges);
      end
   endtask

   // Advance to just after the given edge, sampling 1 time unit past the clock.
   task automatic at_edge(int n);
      while (edges < n) begin
         @(posedge Clk);
         #1;
         edges++;
      end
   endtask

   task automatic release_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      edges = 0;
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_hsync"}, {7'd0, a_hs}, 8'd1);
      check({tag, "_vsync"}, {7'd0, a_vs}, 8'd1);
      check({tag, "_blank"}, {7'd0, a_bl}, 8'd1);
      check({tag, "_ack"}, {7'd0, a_if.AckOut}, 8'd0);
      check({tag, "_pixel"}, a_pix, 8'd0);
      check({tag, "_fs"}, {7'd0, a_fs}, 8'd0);
   endtask

   task automatic run_table(vec_t tbl[$]);
      foreach (tbl[i]) begin
         at_edge(tbl[i].e);
         if (tbl[i].sig == S_DRV) a_if.ReqIn = tbl[i].exp[0];
         else check(tbl[i].nm, get_sig(tbl[i].sig), tbl[i].exp);
      end
   endtask

   vec_t frame1[$];
   vec_t frame2[$];

   initial begin
      // Frame 1: unprimed; line 0 starts at state 36000, output one edge later.
      frame1 = '{
         '{"a_hs_pre",     656, S_AHS, 8'd1}, '{"a_hs_fall",   657, S_AHS, 8'd0},
         '{"a_hs_last",    752, S_AHS, 8'd0}, '{"a_hs_rise",   753, S_AHS, 8'd1},
         '{"b_hs_pre",    1312, S_BHS, 8'd1}, '{"b_hs_fall",  1313, S_BHS, 8'd0},
         '{"a_hs2_pre",   1456, S_AHS, 8'd1}, '{"a_hs2_fall", 1457, S_AHS, 8'd0},
         '{"b_hs_last",   1504, S_BHS, 8'd0}, '{"b_hs_rise",  1505, S_BHS, 8'd1},
         '{"b_hs2_pre",   2912, S_BHS, 8'd1}, '{"b_hs2_fall", 2913, S_BHS, 8'd0},
         '{"b_hs2_last",  3104, S_BHS, 8'd0}, '{"b_hs2_rise", 3105, S_BHS, 8'd1},
         '{"a_vs_pre",    8000, S_AVS, 8'd1}, '{"a_vs_fall",  8001, S_AVS, 8'd0},
         '{"a_vs_last",   9600, S_AVS, 8'd0}, '{"a_vs_rise",  9601, S_AVS, 8'd1},
         '{"b_vs_pre",   16000, S_BVS, 8'd1}, '{"b_vs_fall", 16001, S_BVS, 8'd0},
         '{"b_vs_last",  19200, S_BVS, 8'd0}, '{"b_vs_rise", 19201, S_BVS, 8'd1},
         '{"fs_pre",     36000, S_AFS, 8'd0}, '{"ack_pre",   36000, S_AACK, 8'd0},
         '{"blank_pre",  36000, S_ABL, 8'd1},
         '{"fs_pulse",   36001, S_AFS, 8'd1}, '{"ack_rise",  36001, S_AACK, 8'd1},
         '{"blank_vis",  36001, S_ABL, 8'd0}, '{"fs_post",   36002, S_AFS, 8'd0},
         '{"req_on",     36010, S_DRV, 8'd1}, '{"req_off",   36011, S_DRV, 8'd0},
         '{"unprimed_l0",36081, S_APIX, 8'd0}, '{"unprimed_l1",36881, S_APIX, 8'd0},
         '{"blank_l1",   37100, S_ABL, 8'd0}, '{"ack_l1",    37100, S_AACK, 8'd1}
      };
      // Frame 2: primed by a request in the Clk where AckOut rises.
      frame2 = '{
         '{"r_hs_pre",     656, S_AHS, 8'd1}, '{"r_hs_fall",   657, S_AHS, 8'd0},
         '{"r_vs_fall",   8001, S_AVS, 8'd0}, '{"r_ack_blank",8001, S_AACK, 8'd0},
         '{"r_vs_rise",   9601, S_AVS, 8'd1},
         '{"req_on",     36000, S_DRV, 8'd1}, '{"req_off",   36001, S_DRV, 8'd0},
         '{"r_ack_rise", 36001, S_AACK, 8'd1}, '{"r_fs",      36001, S_AFS, 8'd1},
         '{"pix_h79",    36080, S_APIX, 8'h00}, '{"pix_h80",  36081, S_APIX, 8'hA5},
         '{"pix_h83",    36084, S_APIX, 8'hA5}, '{"pix_h84",  36085, S_APIX, 8'h00},
         '{"pix_h556",   36557, S_APIX, 8'h3C}, '{"pix_h559", 36560, S_APIX, 8'h3C},
         '{"pix_h560",   36561, S_APIX, 8'h00},
         '{"blank_h639", 36640, S_ABL, 8'd0},   '{"blank_h640",36641, S_ABL, 8'd1},
         '{"pix_l3_h80", 38481, S_APIX, 8'hA5}, '{"pix_l3_h559",38960, S_APIX, 8'h3C},
         '{"pix_l4_h80", 39281, S_APIX, 8'h5A}, '{"pix_l4_h556",39757, S_APIX, 8'h00},
         '{"pix_l7_h83", 41684, S_APIX, 8'h5A}, '{"pix_l8_h80", 42481, S_APIX, 8'h00}
      };

      a_if.VgaMat = '0;
      a_if.VgaMat[0 +: IB]          = 8'hA5;  // (0,0)
      a_if.VgaMat[(MN - 1) * IB +: IB] = 8'h3C; // (0,119)
      a_if.VgaMat[MN * IB +: IB]    = 8'h5A;  // (1,0)
      a_if.ReqIn  = 1'b0;
      b_if.VgaMat = '0;
      b_if.ReqIn  = 1'b0;

      // reset and release
      repeat (3) @(posedge Clk);
      #1;
      check_reset_values("in_reset");
      release_reset();
      check_reset_values("release");

      run_table(frame1);

      // mid-line reset at line 1, HCnt 300: outputs clear without a clock edge
      Reset = 1'b0;
      #1;
      check_reset_values("async_rst");
      repeat (2) @(posedge Clk);
      release_reset();
      check_reset_values("rerelease");

      run_table(frame2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
